bcd_normalize: RTL and testbench



---
 rtl/bcd_normalize.sv | 131 +++++++++++++
 tb/tb_bcd_normalize.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_normalize.sv
// Post-subtract normalisation for the decimal FPU datapath.
// Strips leading zero digits or absorbs an overflow digit, then hands off.
module bcd_normalize #(
  parameter int N    = 25,
  parameter int EW   = 16,
  parameter int EMIN = -16383
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*4-1:0]  sig_i,
  input  logic [3:0]      ovf_i,
  input  logic [EW-1:0]   exp_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*4-1:0]  sig_o,
  output logic [EW-1:0]   exp_o,
  output logic            zero_o,
  output logic            inexact_o,
  output logic            sub_o
);

  localparam int W = N * 4;
  localparam logic [EW-1:0] LP_EMIN = EW'(EMIN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RSHIFT,
    ST_LSHIFT,
    ST_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_sig;
  logic [3:0]     r_ovf;
  logic [EW-1:0]  r_exp;
  logic           r_zero;
  logic           r_inexact;
  logic           r_sub;

  logic           w_sig_zero;
  logic           w_msd_nz;
  logic           w_at_emin;

  assign w_sig_zero = (r_sig == '0);
  assign w_msd_nz   = (r_sig[W-1:W-4] != 4'h0);
  assign w_at_emin  = (r_exp == LP_EMIN);

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; LSHIFT exits on zero, normalised MSD or EMIN.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid)
          w_next = (ovf_i != 4'h0) ? ST_RSHIFT : ST_LSHIFT;
      end
      ST_RSHIFT: w_next = ST_DONE;
      ST_LSHIFT: begin
        if (w_sig_zero || w_msd_nz || w_at_emin)
          w_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: load, one right shift, or iterative left shifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig     <= '0;
      r_ovf     <= '0;
      r_exp     <= '0;
      r_zero    <= 1'b0;
      r_inexact <= 1'b0;
      r_sub     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sig     <= sig_i;
            r_ovf     <= ovf_i;
            r_exp     <= exp_i;
            r_zero    <= 1'b0;
            r_inexact <= 1'b0;
            r_sub     <= 1'b0;
          end
        end
        ST_RSHIFT: begin
          r_sig     <= {r_ovf, r_sig[W-1:4]};
          r_exp     <= r_exp + EW'(1);
          r_inexact <= (r_sig[3:0] != 4'h0);
          r_ovf     <= 4'h0;
        end
        ST_LSHIFT: begin
          if (w_sig_zero) begin
            r_zero <= 1'b1;
            r_exp  <= '0;
          end else if (w_msd_nz) begin
            r_zero <= 1'b0;
          end else if (w_at_emin) begin
            r_sub <= 1'b1;
          end else begin
            r_sig <= {r_sig[W-5:0], 4'h0};
            r_exp <= r_exp - EW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign sig_o     = r_sig;
  assign exp_o     = r_exp;
  assign zero_o    = r_zero;
  assign inexact_o = r_inexact;
  assign sub_o     = r_sub;

endmodule

// File: tb/tb_bcd_normalize.sv
// Bench for bcd_normalize at N=4, EMIN=-10.
// Digit-level model plus directed vectors with literal results.
module tb_bcd_normalize;

  localparam int N    = 4;
  localparam int EW   = 16;
  localparam int EMIN = -10;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   sig_i;
  logic [3:0]    ovf_i;
  logic [15:0]   exp_i;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   sig_o;
  logic [15:0]   exp_o;
  logic          zero_o;
  logic          inexact_o;
  logic          sub_o;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 0;

  int m_sig, m_exp, m_zero, m_inex, m_sub, m_lat;

  bcd_normalize #(.N(N), .EW(EW), .EMIN(EMIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sig_i(sig_i), .ovf_i(ovf_i), .exp_i(exp_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .sig_o(sig_o), .exp_o(exp_o),
    .zero_o(zero_o), .inexact_o(inexact_o), .sub_o(sub_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  nm, act, act, req, req);
  endtask

  // Reference: count leading zero digits, shift by as many as EMIN allows.
  task automatic model(input int s, input int o, input int e);
    int lz, room, sh;
    if (o != 0) begin
      m_sig  = (o * 4096) + (s / 16);
      m_exp  = e + 1;
      m_inex = (s % 16) != 0;
      m_zero = 0; m_sub = 0; m_lat = 2;
    end else if (s == 0) begin
      m_sig = 0; m_exp = 0; m_zero = 1;
      m_inex = 0; m_sub = 0; m_lat = 2;
    end else begin
      lz = 0;
      while (((s >> (12 - 4 * lz)) % 16) == 0) lz++;
      room = e - EMIN;
      sh   = (room >= 0 && room < lz) ? room : lz;
      m_sig  = (s * (1 << (4 * sh))) % 65536;
      m_exp  = e - sh;
      m_sub  = sh < lz;
      m_zero = 0; m_inex = 0; m_lat = sh + 2;
    end
  endtask

  // Compare every cycle a result is presented, including stalls.
  always @(negedge clk) begin
    if (rst_n && out_valid && chk_on) begin
      chk("mdl_sig", int'(sig_o), m_sig);
      chk("mdl_exp", int'($signed(exp_o)), m_exp);
      chk("mdl_zero", int'(zero_o), m_zero);
      chk("mdl_inexact", int'(inexact_o), m_inex);
      chk("mdl_sub", int'(sub_o), m_sub);
    end
  end

  task automatic run(input logic [15:0] s, input logic [3:0] o,
                     input int e, input int xs, input int xe,
                     input int xz, input int xi, input int xb,
                     input int stall);
    int k;
    model(int'(s), int'(o), e);
    chk_on = 1;
    @(negedge clk);
    chk("in_ready_idle", int'(in_ready), 1);
    sig_i = s; ovf_i = o; exp_i = 16'(e);
    in_valid = 1; out_ready = 0;
    @(posedge clk);
    #1 in_valid = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 40);
    chk("latency", k, m_lat);
    chk("lit_sig", int'(sig_o), xs);
    chk("lit_exp", int'($signed(exp_o)), xe);
    chk("lit_zero", int'(zero_o), xz);
    chk("lit_inexact", int'(inexact_o), xi);
    chk("lit_sub", int'(sub_o), xb);
    for (int i = 0; i < stall; i++) begin
      chk("in_ready_stall", int'(in_ready), 0);
      sig_i = 16'h0007; ovf_i = 4'h3; exp_i = 16'h0001;
      in_valid = 1;
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("in_ready_after", int'(in_ready), 1);
    chk("valid_after", int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst_n = 0; in_valid = 0; out_ready = 0;
    sig_i = 0; ovf_i = 0; exp_i = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sig", int'(sig_o), 0);
    chk("rst_exp", int'(exp_o), 0);
    chk("rst_flags", int'({zero_o, inexact_o, sub_o}), 0);

    model(16'h0123, 0, 5);
    chk("pin_model_sig", m_sig, 16'h1230);
    chk("pin_model_lat", m_lat, 3);

    run(16'h0123, 4'h0, 5, 16'h1230, 4, 0, 0, 0, 0);
    run(16'h4567, 4'h1, 2, 16'h1456, 3, 0, 1, 0, 0);
    run(16'h4560, 4'h1, 2, 16'h1456, 3, 0, 0, 0, 0);
    run(16'h0000, 4'h0, 7, 16'h0000, 0, 1, 0, 0, 0);
    run(16'h0009, 4'h0, -9, 16'h0090, -10, 0, 0, 1, 0);
    run(16'h1234, 4'h0, 0, 16'h1234, 0, 0, 0, 0, 0);
    run(16'h0005, 4'h0, 3, 16'h5000, 0, 0, 0, 0, 0);
    run(16'h0012, 4'h0, -10, 16'h0012, -10, 0, 0, 1, 0);
    run(16'h9999, 4'h9, -3, 16'h9999, -2, 0, 1, 0, 0);
    run(16'h0450, 4'h0, 1, 16'h4500, 0, 0, 0, 0, 5);

    chk_on = 0;
    @(negedge clk);
    sig_i = 16'h0001; ovf_i = 0; exp_i = 16'd5;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_sig", int'(sig_o), 0);
    chk("abort_exp", int'(exp_o), 0);
    chk("abort_flags", int'({zero_o, inexact_o, sub_o}), 0);
    rst_n = 1;
    out_ready = 1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("no_stale", cnt, 0);
    out_ready = 0;

    run(16'h0001, 4'h0, 5, 16'h1000, 2, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
